// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: rasterises a clipped, solid-colour rectangle into a
// pixel stream (x, y, colour, plot) for a VGA frame-buffer adapter.
`timescale 1ns/1ps
module rect_fill_engine #(
    parameter int XMAX     = 160,
    parameter int YMAX     = 120,
    parameter int COLOUR_W = 3
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic [7:0]          x0,
    input  logic [6:0]          y0,
    input  logic [7:0]          w,
    input  logic [6:0]          h,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [8:0] XMAX_9 = 9'(XMAX);
    localparam logic [8:0] YMAX_9 = 9'(YMAX);

    state_t              r_state;
    state_t              w_state_nxt;

    logic [7:0]          r_x0;
    logic [8:0]          r_xend;
    logic [8:0]          r_yend;
    logic [7:0]          r_x;
    logic [6:0]          r_y;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_plot;
    logic                r_busy;
    logic                r_done;

    logic [8:0]          w_xsum;
    logic [8:0]          w_ysum;
    logic [8:0]          w_xend;
    logic [8:0]          w_yend;
    logic                w_empty;
    logic                w_row_last;
    logic                w_last;

    logic [7:0]          w_x0_nxt;
    logic [8:0]          w_xend_nxt;
    logic [8:0]          w_yend_nxt;
    logic [7:0]          w_x_nxt;
    logic [6:0]          w_y_nxt;
    logic [COLOUR_W-1:0] w_colour_nxt;
    logic                w_plot_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;

    // Clip limits are exclusive and computed at 9 bits so x0+w cannot wrap.
    assign w_xsum     = {1'b0, x0} + {1'b0, w};
    assign w_ysum     = {2'b00, y0} + {2'b00, h};
    assign w_xend     = (w_xsum > XMAX_9) ? XMAX_9 : w_xsum;
    assign w_yend     = (w_ysum > YMAX_9) ? YMAX_9 : w_ysum;
    assign w_empty    = (w == 8'd0) || (h == 7'd0) ||
                        ({1'b0, x0} >= XMAX_9) || ({2'b00, y0} >= YMAX_9);
    assign w_row_last = ({1'b0, r_x} == (r_xend - 9'd1));
    assign w_last     = w_row_last && ({2'b00, r_y} == (r_yend - 9'd1));

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; start is only honoured in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_empty) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_DRAW;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAW: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DRAW;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output/datapath decode: next values for every registered output.
    always_comb begin
        w_x0_nxt     = r_x0;
        w_xend_nxt   = r_xend;
        w_yend_nxt   = r_yend;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_colour_nxt = r_colour;
        w_plot_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_x0_nxt   = x0;
                    w_xend_nxt = w_xend;
                    w_yend_nxt = w_yend;
                    // Empty requests leave the pixel outputs untouched.
                    if (w_empty) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_x_nxt      = x0;
                        w_y_nxt      = y0;
                        w_colour_nxt = colour_in;
                        w_plot_nxt   = 1'b1;
                    end
                end else begin
                    w_done_nxt = 1'b0;
                end
            end
            S_DRAW: begin
                if (w_last) begin
                    w_done_nxt = 1'b1;
                end else if (w_row_last) begin
                    w_x_nxt    = r_x0;
                    w_y_nxt    = r_y + 7'd1;
                    w_plot_nxt = 1'b1;
                end else begin
                    w_x_nxt    = r_x + 8'd1;
                    w_plot_nxt = 1'b1;
                end
            end
            S_DONE: begin
                w_done_nxt = 1'b0;
            end
            default: begin
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Registered outputs and request context.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_x0     <= 8'd0;
            r_xend   <= 9'd0;
            r_yend   <= 9'd0;
            r_x      <= 8'd0;
            r_y      <= 7'd0;
            r_colour <= {COLOUR_W{1'b0}};
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_x0     <= w_x0_nxt;
            r_xend   <= w_xend_nxt;
            r_yend   <= w_yend_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_colour <= w_colour_nxt;
            r_plot   <= w_plot_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: doc/rect_fill_engine.md
RECT_FILL_ENGINE -- requirements
Module: rect_fill_engine

Interface
REQ-001 Parameter XMAX, default 160, screen width in pixels; exclusive x clip limit.
REQ-002 Parameter YMAX, default 120, screen height in pixels; exclusive y clip limit.
REQ-003 Parameter COLOUR_W, default 3, colour width in bits.
REQ-004 Port clock  input  1  single clock for all state; every output is driven from a register on this clock.
REQ-005 Port resetn  input  1  reset, asynchronous, active-low.
REQ-006 Port start  input  1  request to draw a rectangle; sampled only in IDLE.
REQ-007 Port x0  input  8  left column of the rectangle.
REQ-008 Port y0  input  7  top row of the rectangle.
REQ-009 Port w  input  8  width in pixels; 0 means an empty rectangle.
REQ-010 Port h  input  7  height in pixels; 0 means an empty rectangle.
REQ-011 Port colour_in  input  COLOUR_W  fill colour.
REQ-012 Port x  output  8  pixel column to the VGA adapter.
REQ-013 Port y  output  7  pixel row to the VGA adapter.
REQ-014 Port colour  output  COLOUR_W  pixel colour to the VGA adapter.
REQ-015 Port plot  output  1  high for exactly one cycle per pixel written.
REQ-016 Port busy  output  1  high while in DRAW or DONE.
REQ-017 Port done  output  1  one-cycle pulse when a request completes.

Function
REQ-018 FSM states: IDLE, DRAW, DONE.
REQ-019 IDLE with start=1 at edge N: latch x0, y0 and colour_in.
REQ-020 IDLE with start=1 at edge N: compute x_end=min(x0+w, XMAX) and y_end=min(y0+h, YMAX), both at 9 bits with no overflow.
REQ-021 Empty request (w=0, h=0, x0>=XMAX or y0>=YMAX): go to DONE; no plot occurs.
REQ-022 Non-empty request: go to DRAW; the first plot=1 appears in cycle N+1 with x=x0, y=y0.
REQ-023 DRAW scan order: raster, one pixel per cycle with plot=1 every cycle and no gaps.
REQ-024 DRAW, mid-row: x increments.
REQ-025 DRAW, at x=x_end-1: x returns to the latched x0 and y increments.
REQ-026 DRAW, at x=x_end-1 and y=y_end-1: that pixel is the last one; go to DONE.
REQ-027 Plot count per request is exactly (x_end-x0)*(y_end-y0), and no plotted pixel has x>=XMAX or y>=YMAX.
REQ-028 colour equals the latched colour for every plotted pixel; input changes during DRAW have no effect.
REQ-029 DONE: done=1 and plot=0 for one cycle, then IDLE.
REQ-030 start in DRAW or DONE is ignored and is not queued.
REQ-031 Start latency: start held high continuously begins a new request in the first IDLE cycle after DONE.
REQ-032 x, y and colour hold their last values when plot=0.

Reset
REQ-033 resetn=0 asynchronously forces IDLE.
REQ-034 resetn=0 asynchronously clears x, y, colour, plot, busy and done to 0, including mid-DRAW.
REQ-035 After resetn rises, no plot occurs until a new start is sampled in IDLE.

Verification
REQ-036 x0=10, y0=5, w=3, h=2, colour_in=4, start pulse -> 6 consecutive plots (10,5) (11,5) (12,5) (10,6) (11,6) (12,6), colour=4, then done one cycle later, busy low the cycle after.
REQ-037 w=0, h=5, start pulse -> zero plots, done=1 in cycle N+1, busy=1 for exactly one cycle.
REQ-038 x0=158, y0=119, w=5, h=3 -> exactly 2 plots, (158,119) then (159,119), then done.
REQ-039 x0=0, y0=0, w=160, h=120 -> 19200 consecutive plots, first (0,0), last (159,119), done once.
REQ-040 Start a 4x4 draw, pulse start with new coordinates at its 3rd plot -> second request ignored, 16 plots total, single done.
REQ-041 resetn low at the 5th plot of an 8x8 draw -> plot, busy and done go to 0 within the same cycle with no clock edge; no further plots until the next start.
